// File: rtl/lru_replace_ctrl.sv
// Replacement controller for one cache bank: forwards hits to the tree-LRU update port and
// walks each miss through victim choice, optional dirty writeback, refill and fill.
module lru_replace_ctrl #(
    parameter int ASSOCIATIVITY = 4,
    parameter int ENTRIES       = 256,
    parameter int INDEX_BITS    = 8,
    parameter int OUTPUT_BITS   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hit_valid,
    input  logic [INDEX_BITS-1:0]    hit_index,
    input  logic [OUTPUT_BITS-1:0]   hit_way,
    output logic                     hit_ready,
    input  logic                     miss_valid,
    input  logic [INDEX_BITS-1:0]    miss_index,
    input  logic [ASSOCIATIVITY-1:0] miss_valid_vec,
    input  logic [ASSOCIATIVITY-1:0] miss_dirty_vec,
    output logic                     miss_ready,
    output logic                     miss_done,
    output logic [INDEX_BITS-1:0]    line_selector,
    input  logic [OUTPUT_BITS-1:0]   lru_way,
    output logic                     lru_update,
    output logic [OUTPUT_BITS-1:0]   referenced_set,
    output logic                     wb_valid,
    output logic [INDEX_BITS-1:0]    wb_index,
    output logic [OUTPUT_BITS-1:0]   wb_way,
    input  logic                     wb_ready,
    output logic                     mem_req_valid,
    output logic [INDEX_BITS-1:0]    mem_req_index,
    input  logic                     mem_req_ready,
    input  logic                     mem_resp_valid,
    output logic                     fill_valid,
    output logic [INDEX_BITS-1:0]    fill_index,
    output logic [OUTPUT_BITS-1:0]   fill_way
);

    if (ENTRIES != (1 << INDEX_BITS)) begin : g_bad_entries
        $error("ENTRIES must equal 2**INDEX_BITS");
    end
    if (ASSOCIATIVITY != (1 << OUTPUT_BITS) || ASSOCIATIVITY < 4) begin : g_bad_ways
        $error("ASSOCIATIVITY must equal 2**OUTPUT_BITS and be at least 4");
    end

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, REQ, WAIT, FILL} state_t;

    state_t                   state;
    logic [INDEX_BITS-1:0]    idx_q;
    logic [ASSOCIATIVITY-1:0] valid_q;
    logic [ASSOCIATIVITY-1:0] dirty_q;
    logic [OUTPUT_BITS-1:0]   victim_q;

    logic [OUTPUT_BITS-1:0]   first_invalid;
    logic                     any_invalid;
    logic [OUTPUT_BITS-1:0]   lookup_victim;
    logic                     lookup_dirty;
    logic                     hit_window;
    logic                     hit_take;

    // Downward scan so the lowest-numbered invalid way is the one left standing.
    always_comb begin
        first_invalid = '0;
        any_invalid   = 1'b0;
        for (int i = ASSOCIATIVITY - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                first_invalid = OUTPUT_BITS'(i);
                any_invalid   = 1'b1;
            end
        end
        lookup_victim = any_invalid ? first_invalid : lru_way;
        lookup_dirty  = !any_invalid && dirty_q[lru_way];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx_q    <= '0;
            valid_q  <= '0;
            dirty_q  <= '0;
            victim_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_valid && !hit_valid) begin
                        idx_q   <= miss_index;
                        valid_q <= miss_valid_vec;
                        dirty_q <= miss_dirty_vec;
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    victim_q <= lookup_victim;
                    state    <= lookup_dirty ? WB : REQ;
                end
                WB:      if (wb_ready)       state <= REQ;
                REQ:     if (mem_req_ready)  state <= WAIT;
                WAIT:    if (mem_resp_valid) state <= FILL;
                FILL:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign hit_window = (state == IDLE) || (state == WB) || (state == REQ) || (state == WAIT);
    assign hit_take   = hit_window && hit_valid;

    // Outputs are held at zero while reset is asserted, independent of the inputs.
    always_comb begin
        hit_ready      = 1'b0;
        miss_ready     = 1'b0;
        miss_done      = 1'b0;
        line_selector  = '0;
        lru_update     = 1'b0;
        referenced_set = '0;
        wb_valid       = 1'b0;
        wb_index       = '0;
        wb_way         = '0;
        mem_req_valid  = 1'b0;
        mem_req_index  = '0;
        fill_valid     = 1'b0;
        fill_index     = '0;
        fill_way       = '0;
        if (rst_n) begin
            hit_ready     = hit_window;
            miss_ready    = (state == IDLE) && !hit_valid;
            line_selector = (state == IDLE) ? miss_index : idx_q;
            if (hit_take) begin
                line_selector  = hit_index;
                lru_update     = 1'b1;
                referenced_set = hit_way;
            end
            if (state == WB) begin
                wb_valid = 1'b1;
                wb_index = idx_q;
                wb_way   = victim_q;
            end
            if (state == REQ) begin
                mem_req_valid = 1'b1;
                mem_req_index = idx_q;
            end
            if (state == FILL) begin
                fill_valid     = 1'b1;
                fill_index     = idx_q;
                fill_way       = victim_q;
                lru_update     = 1'b1;
                referenced_set = victim_q;
                miss_done      = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lru_replace_ctrl.sv
// Bench for lru_replace_ctrl: directed scenarios followed by randomized misses with
// interleaved hits, compared against a transaction-level model of the miss sequence.
module tb_lru_replace_ctrl;
    localparam int A  = 4;
    localparam int IB = 8;
    localparam int OB = 2;

    localparam int P_IDLE = 0, P_LOOKUP = 1, P_WB = 2, P_REQ = 3, P_WAIT = 4, P_FILL = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hit_valid;
    logic [IB-1:0] hit_index;
    logic [OB-1:0] hit_way;
    logic          hit_ready;
    logic          miss_valid;
    logic [IB-1:0] miss_index;
    logic [A-1:0]  miss_valid_vec;
    logic [A-1:0]  miss_dirty_vec;
    logic          miss_ready;
    logic          miss_done;
    logic [IB-1:0] line_selector;
    logic [OB-1:0] lru_way;
    logic          lru_update;
    logic [OB-1:0] referenced_set;
    logic          wb_valid;
    logic [IB-1:0] wb_index;
    logic [OB-1:0] wb_way;
    logic          wb_ready;
    logic          mem_req_valid;
    logic [IB-1:0] mem_req_index;
    logic          mem_req_ready;
    logic          mem_resp_valid;
    logic          fill_valid;
    logic [IB-1:0] fill_index;
    logic [OB-1:0] fill_way;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int exp_done = 0;

    logic [IB-1:0] m_idx;
    logic [OB-1:0] m_vic;

    lru_replace_ctrl #(.ASSOCIATIVITY(A), .ENTRIES(256), .INDEX_BITS(IB), .OUTPUT_BITS(OB)) dut (
        .clk(clk), .rst_n(rst_n),
        .hit_valid(hit_valid), .hit_index(hit_index), .hit_way(hit_way), .hit_ready(hit_ready),
        .miss_valid(miss_valid), .miss_index(miss_index), .miss_valid_vec(miss_valid_vec),
        .miss_dirty_vec(miss_dirty_vec), .miss_ready(miss_ready), .miss_done(miss_done),
        .line_selector(line_selector), .lru_way(lru_way), .lru_update(lru_update),
        .referenced_set(referenced_set),
        .wb_valid(wb_valid), .wb_index(wb_index), .wb_way(wb_way), .wb_ready(wb_ready),
        .mem_req_valid(mem_req_valid), .mem_req_index(mem_req_index),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .fill_valid(fill_valid), .fill_index(fill_index), .fill_way(fill_way)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (miss_done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Victim rule: lowest invalid way, otherwise the LRU's choice.
    function automatic int model_victim(input logic [A-1:0] vv, input logic [OB-1:0] lru);
        for (int i = 0; i < A; i++) if (!vv[i]) return i;
        return int'(lru);
    endfunction

    task automatic chk_all_zero(input string tag);
        logic [31:0] agg;
        agg = 32'(hit_ready) | 32'(miss_ready) | 32'(miss_done) | 32'(line_selector)
            | 32'(lru_update) | 32'(referenced_set) | 32'(wb_valid) | 32'(wb_index)
            | 32'(wb_way) | 32'(mem_req_valid) | 32'(mem_req_index) | 32'(fill_valid)
            | 32'(fill_index) | 32'(fill_way);
        chk(tag, agg, 32'd0);
    endtask

    task automatic expect_cycle(input int ph);
        logic hit_ok, acc;
        logic [IB-1:0] exp_sel;
        logic [OB-1:0] exp_ref;
        hit_ok  = (ph == P_IDLE) || (ph == P_WB) || (ph == P_REQ) || (ph == P_WAIT);
        acc     = hit_ok && hit_valid;
        exp_sel = acc ? hit_index : ((ph == P_IDLE) ? miss_index : m_idx);
        exp_ref = acc ? hit_way : ((ph == P_FILL) ? m_vic : '0);
        chk($sformatf("hit_ready ph%0d", ph), 32'(hit_ready), 32'(hit_ok));
        chk($sformatf("miss_ready ph%0d", ph), 32'(miss_ready), 32'((ph == P_IDLE) && !hit_valid));
        chk($sformatf("lru_update ph%0d", ph), 32'(lru_update), 32'(acc || (ph == P_FILL)));
        chk($sformatf("line_selector ph%0d", ph), 32'(line_selector), 32'(exp_sel));
        chk($sformatf("referenced_set ph%0d", ph), 32'(referenced_set), 32'(exp_ref));
        chk($sformatf("wb_valid ph%0d", ph), 32'(wb_valid), 32'(ph == P_WB));
        chk($sformatf("mem_req_valid ph%0d", ph), 32'(mem_req_valid), 32'(ph == P_REQ));
        chk($sformatf("fill_valid ph%0d", ph), 32'(fill_valid), 32'(ph == P_FILL));
        chk($sformatf("miss_done ph%0d", ph), 32'(miss_done), 32'(ph == P_FILL));
        if (ph == P_WB) begin
            chk("wb_index", 32'(wb_index), 32'(m_idx));
            chk("wb_way", 32'(wb_way), 32'(m_vic));
        end
        if (ph == P_REQ) chk("mem_req_index", 32'(mem_req_index), 32'(m_idx));
        if (ph == P_FILL) begin
            chk("fill_index", 32'(fill_index), 32'(m_idx));
            chk("fill_way", 32'(fill_way), 32'(m_vic));
        end
    endtask

    task automatic rand_hit(input bit en);
        hit_valid = en ? 1'($urandom_range(0, 1)) : 1'b0;
        hit_index = IB'($urandom_range(0, 255));
        hit_way   = OB'($urandom_range(0, A - 1));
    endtask

    // hmode: 0 no hits, 1 random hits, 2 one forced hit (same set, way 0) on the first WAIT cycle.
    task automatic run_miss(input logic [IB-1:0] idx, input logic [A-1:0] vv, input logic [A-1:0] dv,
                            input logic [OB-1:0] lru, input int wbw, input int rqw, input int rsw,
                            input int hmode);
        int vic;
        bit do_wb;
        vic   = model_victim(vv, lru);
        do_wb = (vv == '1) && dv[vic];
        m_idx = idx;
        m_vic = OB'(vic);

        @(negedge clk);
        hit_valid = 1'b0; miss_valid = 1'b1; miss_index = idx;
        miss_valid_vec = vv; miss_dirty_vec = dv; lru_way = lru;
        #1 expect_cycle(P_IDLE);

        @(negedge clk);
        miss_valid = 1'b0;
        miss_valid_vec = A'($urandom_range(0, 15));
        miss_dirty_vec = A'($urandom_range(0, 15));
        miss_index = IB'($urandom_range(0, 255));
        rand_hit(hmode != 0);
        #1 expect_cycle(P_LOOKUP);

        if (do_wb) begin
            for (int i = 0; i <= wbw; i++) begin
                @(negedge clk);
                lru_way = OB'($urandom_range(0, A - 1));
                rand_hit(hmode == 1);
                wb_ready = (i == wbw);
                mem_req_ready = 1'($urandom_range(0, 1));
                mem_resp_valid = 1'($urandom_range(0, 1));
                #1 expect_cycle(P_WB);
            end
        end
        for (int i = 0; i <= rqw; i++) begin
            @(negedge clk);
            lru_way = OB'($urandom_range(0, A - 1));
            rand_hit(hmode == 1);
            wb_ready = 1'($urandom_range(0, 1));
            mem_req_ready = (i == rqw);
            mem_resp_valid = 1'($urandom_range(0, 1));
            #1 expect_cycle(P_REQ);
        end
        for (int i = 0; i <= rsw; i++) begin
            @(negedge clk);
            lru_way = OB'($urandom_range(0, A - 1));
            rand_hit(hmode == 1);
            if (hmode == 2 && i == 0) begin
                hit_valid = 1'b1; hit_index = idx; hit_way = '0;
            end
            wb_ready = 1'($urandom_range(0, 1));
            mem_req_ready = 1'($urandom_range(0, 1));
            mem_resp_valid = (i == rsw);
            #1 expect_cycle(P_WAIT);
        end
        @(negedge clk);
        mem_resp_valid = 1'b0; wb_ready = 1'b0; mem_req_ready = 1'b0;
        rand_hit(hmode != 0);
        #1 expect_cycle(P_FILL);
        exp_done++;
        @(negedge clk);
        hit_valid = 1'b0;
        #1 expect_cycle(P_IDLE);
    endtask

    initial begin
        rst_n = 1'b0;
        hit_valid = 1'b1; hit_index = 8'h33; hit_way = 2'd2;
        miss_valid = 1'b1; miss_index = 8'h44; miss_valid_vec = '1; miss_dirty_vec = '1;
        lru_way = 2'd1; wb_ready = 1'b1; mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
        m_idx = '0; m_vic = '0;
        repeat (2) @(negedge clk);
        #1 chk_all_zero("reset_outputs_zero");
        @(negedge clk);
        rst_n = 1'b1;
        hit_valid = 1'b0; miss_valid = 1'b0; wb_ready = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        #1 expect_cycle(P_IDLE);

        // First invalid way wins over the LRU choice; no writeback.
        run_miss(8'h12, 4'b1011, 4'b1111, 2'd3, 0, 0, 1, 0);
        // Dirty LRU victim: writeback held for three cycles.
        run_miss(8'h40, 4'b1111, 4'b0010, 2'd1, 2, 1, 2, 0);
        // Clean LRU victim: straight to the refill request.
        run_miss(8'h40, 4'b1111, 4'b0000, 2'd1, 0, 0, 0, 0);

        // Hit and miss together in IDLE: the hit goes first.
        @(negedge clk);
        hit_valid = 1'b1; hit_index = 8'h05; hit_way = 2'd3;
        miss_valid = 1'b1; miss_index = 8'h20; miss_valid_vec = 4'b0111; miss_dirty_vec = '0;
        #1 expect_cycle(P_IDLE);
        run_miss(8'h20, 4'b0111, 4'b0000, 2'd0, 0, 0, 0, 0);

        // Hit to the in-flight set while waiting on memory.
        run_miss(8'h40, 4'b1111, 4'b1000, 2'd3, 1, 0, 2, 2);

        // Reset in WAIT aborts the miss without a completion pulse.
        m_idx = 8'h77; m_vic = 2'd2;
        @(negedge clk);
        miss_valid = 1'b1; miss_index = 8'h77; miss_valid_vec = '1; miss_dirty_vec = '0; lru_way = 2'd2;
        #1 expect_cycle(P_IDLE);
        @(negedge clk);
        miss_valid = 1'b0;
        #1 expect_cycle(P_LOOKUP);
        @(negedge clk);
        mem_req_ready = 1'b1;
        #1 expect_cycle(P_REQ);
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1 expect_cycle(P_WAIT);
        rst_n = 1'b0;
        mem_resp_valid = 1'b1;
        #1 chk_all_zero("reset_mid_wait_zero");
        repeat (2) @(negedge clk);
        #1 chk_all_zero("reset_held_zero");
        rst_n = 1'b1;
        mem_resp_valid = 1'b0;
        miss_index = 8'h00;
        #1 expect_cycle(P_IDLE);
        @(negedge clk);
        #1 expect_cycle(P_IDLE);

        // Randomized misses with interleaved hits.
        for (int n = 0; n < 40; n++) begin
            logic [A-1:0] vv;
            vv = ($urandom_range(0, 1) == 1) ? '1 : A'($urandom_range(0, 15));
            run_miss(IB'($urandom_range(0, 255)), vv, A'($urandom_range(0, 15)),
                     OB'($urandom_range(0, A - 1)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1);
        end

        @(negedge clk);
        chk("miss_done_count", 32'(done_cnt), 32'(exp_done));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lru_replace_ctrl.md
Name: lru_replace_ctrl

Overview:
- Miss/hit-side controller that drives the read and update ports of the tree-LRU (`lrumore`/`lru2`) for one cache bank.
- On a hit it issues an LRU update for the hit way.
- On a miss it reads the LRU victim, or the lowest invalid way, then sequences optional dirty writeback, memory refill and fill write.
- It closes each miss with the LRU update for the filled way.
- Sits between the cache tag/data arrays, the memory request port and the LRU instance.

Parameters:
- ASSOCIATIVITY, 4, number of ways (power of two, ≥4).
- ENTRIES, 256, number of sets.
- INDEX_BITS, 8, set index width (log2 ENTRIES).
- OUTPUT_BITS, 2, way index width (log2 ASSOCIATIVITY).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hit_valid  in  1  hit notification.
- hit_index  in  INDEX_BITS  set of hit.
- hit_way  in  OUTPUT_BITS  way of hit.
- hit_ready  out  1  hit accepted this cycle.
- miss_valid  in  1  miss request.
- miss_index  in  INDEX_BITS  set of miss.
- miss_valid_vec  in  ASSOCIATIVITY  per-way valid bits of the miss set.
- miss_dirty_vec  in  ASSOCIATIVITY  per-way dirty bits of the miss set.
- miss_ready  out  1  miss accepted this cycle.
- miss_done  out  1  one-cycle pulse, miss complete.
- line_selector  out  INDEX_BITS  LRU read/update index.
- lru_way  in  OUTPUT_BITS  LRU victim for line_selector (combinational).
- lru_update  out  1  LRU update strobe.
- referenced_set  out  OUTPUT_BITS  way being referenced.
- wb_valid  out  1  writeback request.
- wb_index  out  INDEX_BITS  writeback set.
- wb_way  out  OUTPUT_BITS  writeback way.
- wb_ready  in  1  writeback accepted.
- mem_req_valid  out  1  refill request.
- mem_req_index  out  INDEX_BITS  refill set.
- mem_req_ready  in  1  refill request accepted.
- mem_resp_valid  in  1  refill data returned.
- fill_valid  out  1  one-cycle fill write strobe.
- fill_index  out  INDEX_BITS  fill set.
- fill_way  out  OUTPUT_BITS  fill way.

Behaviour:
- FSM states: IDLE, LOOKUP, WB, REQ, WAIT, FILL. Reset → IDLE.
- Reset values: every output 0. Latched index, victim way and dirty flag cleared to 0.
- Reset asserted mid-operation aborts any miss immediately; no miss_done is produced for the aborted miss.

IDLE:
- hit_ready=1.
- If hit_valid: line_selector=hit_index, lru_update=1, referenced_set=hit_way, miss_ready=0. Hits have priority.
- Else miss_ready=1. On miss_valid, latch miss_index, miss_valid_vec and miss_dirty_vec, then go to LOOKUP.

LOOKUP (1 cycle):
- hit_ready=0; line_selector=latched index.
- Victim is the lowest-numbered way whose latched valid bit is 0. If all ways are valid, victim=lru_way sampled this cycle. Latch the victim.
- If the victim is valid and dirty → WB, else → REQ.

WB:
- wb_valid=1 with wb_index=latched index, wb_way=victim.
- wb_index and wb_way are held stable until wb_ready; the transfer completes in the cycle both are high, then → REQ.

REQ:
- mem_req_valid=1, mem_req_index=latched index, held stable until mem_req_ready.
- Handshake cycle → WAIT.

WAIT:
- Stays until mem_resp_valid=1 → FILL.
- mem_resp_valid outside WAIT is ignored.

FILL (1 cycle):
- fill_valid=1, fill_index=latched index, fill_way=victim.
- In the same cycle: line_selector=latched index, lru_update=1, referenced_set=victim, miss_done=1.
- hit_ready=0. Next state IDLE.

Hits during WB/REQ/WAIT:
- hit_ready=1. Same response as in IDLE: line_selector=hit_index, lru_update=1, referenced_set=hit_way, zero added latency.
- A hit to the in-flight miss index is legal; the LRU state changes but the already-latched victim does not.

Hits during LOOKUP/FILL:
- hit_ready=0. The hit source holds hit_valid until accepted.

Other rules:
- miss_ready=0 in every state except IDLE. At most one miss is outstanding.
- lru_update is only asserted on an accepted hit or in FILL, never both in the same cycle.
- When lru_update=0, line_selector=latched index in non-IDLE states and miss_index in IDLE; referenced_set=0.

Test Plan:
- Reset with rst_n=0 mid-WAIT, released 2 cycles later → state IDLE, all outputs 0, no miss_done pulse.
- Miss on index 0x12 with valid_vec=4'b1011, lru_way=3 → fill_way=2 (first invalid way, LRU ignored), no wb_valid. FILL cycle shows lru_update=1, referenced_set=2, line_selector=0x12, miss_done=1.
- Miss on index 0x40 with valid_vec=4'b1111, dirty_vec=4'b0010, lru_way=1 → wb_valid with wb_way=1 held 3 cycles until wb_ready, then mem_req_valid, then fill_way=1.
- Same as above but dirty_vec=4'b0000 → no wb_valid; mem_req_valid asserts the cycle after LOOKUP.
- hit_valid and miss_valid both asserted in IDLE with hit_index=0x05, hit_way=3 → lru_update=1, referenced_set=3, miss_ready=0; the miss is accepted on the following cycle.
- Hit on index 0x40, way 0 while in WAIT → immediate lru_update with referenced_set=0. The later FILL still uses the latched victim, and only one update is seen per cycle.
